la_dmuxn_reg: RTL and testbench
===============================

Name: la_dmuxn_reg

Overview:
- Parametrised, registered one-hot data multiplexer: N inputs of DW bits, merged by AND-OR reduction under a one-hot select.
- Result is delivered through a 2-entry skid buffer with valid/ready handshake on both sides.
- Used where wide one-hot selection sits on a timing-critical path between pipeline stages.
- Adds a sticky one-hot-violation monitor that can be compiled out.

Parameters:
- N, 6, number of inputs (>=2)
- DW, 1, data width per input (>=1)
- PROP, "DEFAULT", cell property string passed through to the sub-module

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- sel  in  N  one-hot select; bit i selects input i
- in  in  N*DW  packed inputs; input i = in[i*DW +: DW]
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat
- out  out  DW  registered mux result
- out_valid  out  1  out holds a valid beat
- out_ready  in  1  downstream accepts beat
- err_clear  in  1  clears err_onehot
- err_onehot  out  1  sticky: accepted beat had popcount(sel)!=1
- err_count  out  8  saturating count of violating accepted beats

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high. Assertion immediately forces the reset values below; deassertion is synchronous to clk.
- Combinational result: mux = OR over i of ({DW{sel[i]}} & in_i).
  - sel==0 gives all-zero data.
  - Multi-hot sel gives the bitwise OR of the selected inputs; this is not masked.
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- States: EMPTY, ONE (main register valid), TWO (main and skid registers valid).
  - EMPTY: accept -> ONE, main <= mux.
  - ONE:
    - accept & !emit -> TWO, skid <= mux.
    - emit & !accept -> EMPTY.
    - accept & emit -> stays ONE, main <= mux.
  - TWO:
    - emit -> ONE, main <= skid. No accept is possible, since in_ready=0.
- Output decode:
  - in_ready = (state != TWO); driven from a register, so there is no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - out = main.
- Latency and throughput: latency is 1 cycle from accept to out_valid. Sustained throughput is 1 beat/cycle when out_ready is held at 1.
- Ordering: beats emerge strictly in acceptance order. No beat is dropped or duplicated.
- Data hold: while out_valid=1 and out_ready=0, out must not change.
- Reset values: state=EMPTY, in_ready=1 after reset release, out_valid=0, out=0, main=skid=0, err_onehot=0, err_count=0.
- Reset mid-operation: all held beats are discarded, with no partial emission.
- Error monitor (only checks accepted beats):
  - On accept with popcount(sel)!=1: err_onehot <= 1, and err_count increments, saturating at 255.
  - err_clear has priority over a same-cycle set: err_onehot <= 0, err_count <= 0.
  - sel is ignored when in_valid=0.

Optional Feature:
- Macro: LA_DMUXN_ONEHOT_CHECK_EN.
- Defined: the popcount monitor, err_onehot and err_count are implemented as specified above.
- Undefined: the monitor logic is removed, err_onehot and err_count are tied to 0, err_clear is ignored, and the datapath is unchanged.

Decomposition:
- Package la_dmuxn_pkg: state enum (EMPTY/ONE/TWO, 2 bits), localparam ERRW=8, ERR_MAX=255.
- Sub-module la_dmuxn_comb (params N, DW, PROP): pure AND-OR reduction, instanced once.
- The top level holds the skid FSM, the registers and the monitor.

Test Plan:
- Reset/idle: assert reset for 3 cycles, release -> out_valid=0, in_ready=1, out=0, err_onehot=0, err_count=0.
- Streaming: N=6, DW=8, out_ready=1, 6 beats with sel=1<<i and in_i=8'h10+i -> out 8'h10..8'h15 on consecutive cycles, 1-cycle latency.
- Backpressure: out_ready=0, send 3 beats -> first two accepted, in_ready=0 on cycle 3. Raise out_ready -> beats emerge in order, data held stable while stalled.
- Illegal select: sel=6'b000000 then sel=6'b000011 with in0=8'hF0, in1=8'h0F -> outputs 8'h00 and 8'hFF, err_onehot=1, err_count=2. Then err_clear together with another illegal beat -> err_onehot=0, err_count=0.
- Saturation and reset mid-flight: 300 illegal beats -> err_count=255. Then assert reset while in state TWO -> out_valid drops immediately, nothing further is emitted.
- Compiled without LA_DMUXN_ONEHOT_CHECK_EN: repeat the illegal-select scenario -> same out data, err_onehot=0, err_count=0.

Source files
------------

// File: rtl/la_dmuxn_pkg.sv
// Shared types and constants for the registered one-hot mux (la_dmuxn_reg).
package la_dmuxn_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int unsigned ERRW = 8;
  localparam logic [ERRW-1:0] ERR_MAX = ERRW'(255);

endpackage

// File: rtl/la_dmuxn_comb.sv
// Pure AND-OR reduction of N packed DW-bit inputs under a select vector.
module la_dmuxn_comb #(
  parameter int unsigned N    = 6,
  parameter int unsigned DW   = 1,
  parameter              PROP = "DEFAULT"
) (
  input  logic [N-1:0]    sel,
  input  logic [N*DW-1:0] in,
  output logic [DW-1:0]   mux_c
);

  if (N < 2 || DW < 1) begin : g_param_check
    $error("la_dmuxn_comb (%s): requires N >= 2 and DW >= 1", PROP);
  end

  // Multi-hot selects OR together; no masking is applied here.
  always_comb begin
    mux_c = '0;
    for (int i = 0; i < N; i++) begin
      mux_c = mux_c | ({DW{sel[i]}} & in[i*DW +: DW]);
    end
  end

endmodule

// File: rtl/la_dmuxn_reg.sv
// Registered one-hot mux with a 2-entry skid buffer on a valid/ready interface.
// Optional sticky one-hot monitor enabled by LA_DMUXN_ONEHOT_CHECK_EN.
module la_dmuxn_reg
  import la_dmuxn_pkg::*;
#(
  parameter int unsigned N    = 6,
  parameter int unsigned DW   = 1,
  parameter              PROP = "DEFAULT"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    sel,
  input  logic [N*DW-1:0] in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic            err_clear,
  output logic            err_onehot,
  output logic [ERRW-1:0] err_count
);

  logic [DW-1:0] mux_c;
  logic          accept_c;
  logic          emit_c;
  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;

  la_dmuxn_comb #(
    .N    (N),
    .DW   (DW),
    .PROP (PROP)
  ) u_comb (
    .sel   (sel),
    .in    (in),
    .mux_c (mux_c)
  );

  assign accept_c = in_valid & in_ready;
  assign emit_c   = out_valid & out_ready;
  assign out      = main_q;

  // Skid buffer next-state and register updates.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept_c) begin
          state_d = ONE;
          main_d  = mux_c;
        end
      end
      ONE: begin
        if (accept_c && !emit_c) begin
          state_d = TWO;
          skid_d  = mux_c;
        end else if (emit_c && !accept_c) begin
          state_d = EMPTY;
        end else if (accept_c && emit_c) begin
          main_d = mux_c;
        end
      end
      TWO: begin
        if (emit_c) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      in_ready  <= (state_d != TWO);
      out_valid <= (state_d != EMPTY);
    end
  end

`ifdef LA_DMUXN_ONEHOT_CHECK_EN
  logic viol_c;

  assign viol_c = accept_c & ~$onehot(sel);

  // Clear wins over a same-cycle violation; the count saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_onehot <= 1'b0;
      err_count  <= '0;
    end else if (err_clear) begin
      err_onehot <= 1'b0;
      err_count  <= '0;
    end else if (viol_c) begin
      err_onehot <= 1'b1;
      if (err_count != ERR_MAX) begin
        err_count <= err_count + ERRW'(1);
      end
    end
  end
`else
  logic unused_err_clear;

  assign unused_err_clear = err_clear;
  assign err_onehot       = 1'b0;
  assign err_count        = '0;
`endif

endmodule

// File: tb/tb_la_dmuxn_reg.sv
// Scoreboard bench for la_dmuxn_reg (N=6, DW=8); honours LA_DMUXN_ONEHOT_CHECK_EN.
module tb_la_dmuxn_reg;

  localparam int unsigned N  = 6;
  localparam int unsigned DW = 8;
`ifdef LA_DMUXN_ONEHOT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [N-1:0]  sel;
  logic [N*DW-1:0] in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out;
  logic          out_valid;
  logic          out_ready;
  logic          err_clear;
  logic          err_onehot;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic          exp_err;
  int            exp_cnt;
  logic          prev_stall;
  logic [DW-1:0] prev_out;

  la_dmuxn_reg #(.N(N), .DW(DW), .PROP("DEFAULT")) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .in         (in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_clear  (err_clear),
    .err_onehot (err_onehot),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] ref_mux(input logic [N-1:0] s, input logic [N*DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (s[i]) r = r | d[i*DW +: DW];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop on emit, track hold and error model.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_err    = 1'b0;
      exp_cnt    = 0;
      prev_stall = 1'b0;
      check("reset_out_valid", 32'(out_valid), 32'd0);
    end else begin
      check("err_onehot", 32'(err_onehot), 32'(exp_err));
      check("err_count", 32'(err_count), 32'(exp_cnt));
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_emit: got data %0h with empty scoreboard", out);
        end else begin
          check("out_data", 32'(out), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_out   = out;
      if (in_valid && in_ready) exp_q.push_back(ref_mux(sel, in));
      if (CHK_EN) begin
        if (err_clear) begin
          exp_err = 1'b0;
          exp_cnt = 0;
        end else if (in_valid && in_ready && $countones(sel) != 1) begin
          exp_err = 1'b1;
          if (exp_cnt < 255) exp_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [N-1:0] s, input logic [N*DW-1:0] d, input logic clr);
    bit done;
    done      = 1'b0;
    sel       = s;
    in        = d;
    err_clear = clr;
    in_valid  = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %0d", in_ready);
    end
    step();
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d out_valid %0d", exp_q.size(), out_valid);
    end
    step();
  endtask

  function automatic logic [N-1:0] illegal_sel();
    logic [N-1:0] s;
    s = N'($urandom);
    while ($countones(s) == 1) s = N'($urandom);
    return s;
  endfunction

  initial begin
    logic [N*DW-1:0] d, da, db, dc;
    reset     = 1'b1;
    sel       = '0;
    in        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out", 32'(out), 32'd0);
    check("rst_err_onehot", 32'(err_onehot), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    step();

    // Streaming at one beat per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(8'h10 + i);
    for (int i = 0; i < N; i++) begin
      send(N'(1 << i), d, 1'b0);
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out), 32'(8'h10 + i));
    end
    idle();
    wait_drain();

    // Backpressure: two beats fill the buffer, third waits.
    out_ready = 1'b0;
    da = {$urandom(), $urandom()};
    db = {$urandom(), $urandom()};
    dc = {$urandom(), $urandom()};
    send(6'b000001, da, 1'b0);
    send(6'b001000, db, 1'b0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_head", 32'(out), 32'(da[7:0]));
    sel = 6'b100000;
    in  = dc;
    repeat (3) step();
    out_ready = 1'b1;
    send(6'b100000, dc, 1'b0);
    idle();
    wait_drain();

    // Illegal selects: zero and multi-hot.
    d        = {$urandom(), $urandom()};
    d[7:0]   = 8'hF0;
    d[15:8]  = 8'h0F;
    send(6'b000000, d, 1'b0);
    check("illegal_zero", 32'(out), 32'h00);
    send(6'b000011, d, 1'b0);
    check("illegal_or", 32'(out), 32'hFF);
    idle();
    wait_drain();
    check("illegal_err_onehot", 32'(err_onehot), CHK_EN ? 32'd1 : 32'd0);
    check("illegal_err_count", 32'(err_count), CHK_EN ? 32'd2 : 32'd0);
    send(6'b000101, d, 1'b1);
    idle();
    check("clear_err_onehot", 32'(err_onehot), 32'd0);
    check("clear_err_count", 32'(err_count), 32'd0);
    step();

    // Saturation of the violation counter.
    for (int i = 0; i < 300; i++) send(illegal_sel(), {$urandom(), $urandom()}, 1'b0);
    idle();
    wait_drain();
    check("sat_err_count", 32'(err_count), CHK_EN ? 32'd255 : 32'd0);
    check("sat_err_onehot", 32'(err_onehot), CHK_EN ? 32'd1 : 32'd0);

    // Reset while two beats are held.
    out_ready = 1'b0;
    send(6'b000010, {$urandom(), $urandom()}, 1'b0);
    send(6'b000100, {$urandom(), $urandom()}, 1'b0);
    check("mid_full", 32'(in_ready), 32'd0);
    idle();
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    step();
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check("mid_after_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      sel       = ($urandom_range(3) == 0) ? N'($urandom) : N'(1 << $urandom_range(N - 1));
      in        = {$urandom(), $urandom()};
      err_clear = ($urandom_range(19) == 0);
      step();
    end
    idle();
    out_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
